c17_stress_bist: RTL and testbench
==================================

// Module: c17_stress_bist
// PURPOSE
//  Stimulus driver and response checker for NCOPIES c17 NAND2 netlist copies under aging stress.
//  Broadcasts a 5-bit LFSR vector to every copy and samples each copy's N22/N23 one clock later.
//  Compares the samples against a built-in golden c17 model, counts mismatches and compacts copy
//  responses into a MISR signature. It sits between the experiment sequencer and the gate-level DUT.
// PARAMETERS
//  NCOPIES    2        number of c17 copies checked, 1..8
//  CNT_W      16       width of pattern count, index and error counter
//  LFSR_SEED  16'hACE1 LFSR reload value on start; a zero value is replaced by 16'h0001
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous active-low reset
//  start          in   1          begin run; sampled in IDLE/DONE, ignored while busy
//  abort          in   1          terminate run, return to IDLE
//  num_pat        in   CNT_W      patterns per run, sampled on start
//  stim           out  5          to DUT: [0]=N1 [1]=N2 [2]=N3 [3]=N6 [4]=N7
//  resp           in   2*NCOPIES  from DUT: copy k [2k]=N22 [2k+1]=N23
//  busy           out  1          high in RUN/DRAIN
//  done           out  1          high in DONE
//  pass           out  1          no mismatch in last completed run
//  err_cnt        out  CNT_W      mismatching patterns, saturates at all-ones
//  first_err_idx  out  CNT_W      index of first mismatching pattern, valid when pass=0
//  err_copy_mask  out  NCOPIES    sticky per-copy mismatch flags
//  signature      out  16         MISR of resp
// BEHAVIOUR
//  Reset: state=IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, mask=0, sig=0.
//  Reset mid-run: same values, applied on the next edge.
//  States: IDLE -(start & !abort)-> RUN; RUN -(idx==num_pat-1)-> DRAIN; DRAIN -> DONE.
//  More transitions: DONE -start-> RUN; abort in RUN/DRAIN -> IDLE.
//  num_pat==0: start goes directly to DONE with pass=1, err_cnt=0, sig=0.
//  On start: lfsr<=seed, idx<=0, err_cnt/first_err_idx/mask/sig cleared, pass<=1.
//  RUN, each edge: stim<=lfsr[4:0], cmp_en<=1, idx++.
//  RUN, LFSR step: lfsr<={lfsr[14:0], l15^l13^l12^l10}.
//  Compare: on each edge with cmp_en=1, resp is checked against golden(stim), using current stim reg.
//  Golden model: n10=~(N1&N3) n11=~(N3&N6) n16=~(N2&n11) n19=~(n11&N7) N22=~(n10&n16) N23=~(n16&n19).
//  Mismatch if any copy differs from golden. On mismatch: pass<=0, err_cnt++ (saturating).
//  Also on mismatch: mask|=differing copies; first_err_idx<=pattern index, first mismatch only.
//  MISR on every compare: sig<={sig[14:0], s15^s13^s12^s10} ^ zero-extended resp.
//  DRAIN: performs the final compare, then stim<=0 and cmp_en<=0.
//  Latency: done rises num_pat+1 edges after the edge that samples start.
//  DUT settling time must be under one clk period.
//  Abort: stim<=0, cmp_en<=0, done stays 0; result outputs freeze until the next start.
//  Simultaneous start & abort in IDLE/DONE: abort wins and the state goes to IDLE.
// CONFIGURATION
//  C17_BIST_HOLD_EN defined: adds inputs hold_mode(1) and hold_vec(5) for DC stress.
//   With hold_mode=1 sampled at start, the whole run drives stim=hold_vec instead of the LFSR.
//   The LFSR is frozen, and compare and MISR operate unchanged.
//  Undefined: the ports are absent and the block runs LFSR-only.
// TESTING
//  Reset with outputs forced: rst_n=0 one edge -> all outputs 0, state IDLE.
//  num_pat=1, good DUT: first stim=5'b00001, resp=2'b00/copy -> done after 2 edges, pass=1, err_cnt=0.
//  num_pat=256, golden-correct resp -> pass=1, err_cnt=0, mask=0, signature matches reference model.
//  Force copy1 N22=1 constantly, num_pat=8 -> err_cnt = patterns with golden N22=0, mask=2'b10.
//  Same forced run -> first_err_idx = first such index.
//  abort at RUN cycle 3 -> IDLE next edge, stim=0, done=0; start while busy is ignored.
//  HOLD_EN: hold_vec=5'b11111, num_pat=4 -> stim=5'b11111 for 4 cycles, expected N22=1 N23=0, pass=1.

Source files
------------

// File: rtl/c17_stress_bist.sv
// LFSR stimulus driver and golden-model response checker for NCOPIES c17 netlist copies.
// Define C17_BIST_HOLD_EN to add hold_mode_i/hold_vec_i for fixed-vector DC stress runs.
module c17_stress_bist #(
  parameter int unsigned NCOPIES   = 2,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_W-1:0]     num_pat_i,
  output logic [4:0]           stim_o,
  input  logic [2*NCOPIES-1:0] resp_i,
`ifdef C17_BIST_HOLD_EN
  input  logic                 hold_mode_i,
  input  logic [4:0]           hold_vec_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     first_err_idx_o,
  output logic [NCOPIES-1:0]   err_copy_mask_o,
  output logic [15:0]          signature_o
);

  localparam logic [15:0]      Seed   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   num_pat_q, num_pat_d;
  logic [4:0]         stim_q, stim_d;
  logic               cmp_en_q, cmp_en_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   first_err_q, first_err_d;
  logic [NCOPIES-1:0] mask_q, mask_d;
  logic [15:0]        sig_q, sig_d;

  logic               start_ok;
  logic               do_cmp;
  logic [1:0]         gold;
  logic [NCOPIES-1:0] diff;
  logic               hold_act;
  logic [4:0]         hold_vec;

  function automatic logic [1:0] c17_golden(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  assign start_ok = start_i & ~abort_i & ((state_q == StIdle) | (state_q == StDone));

`ifdef C17_BIST_HOLD_EN
  logic       hold_q;
  logic [4:0] hold_vec_q;

  // Hold configuration is latched once per run, like num_pat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q     <= 1'b0;
      hold_vec_q <= '0;
    end else if (start_ok) begin
      hold_q     <= hold_mode_i;
      hold_vec_q <= hold_vec_i;
    end
  end

  assign hold_act = hold_q;
  assign hold_vec = hold_vec_q;
`else
  assign hold_act = 1'b0;
  assign hold_vec = 5'b00000;
`endif

  always_comb begin
    gold = c17_golden(stim_q);
    diff = '0;
    for (int k = 0; k < int'(NCOPIES); k++) begin
      diff[k] = (resp_i[2*k +: 2] != gold);
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    num_pat_d   = num_pat_q;
    stim_d      = stim_q;
    cmp_en_d    = cmp_en_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    mask_d      = mask_q;
    sig_d       = sig_q;
    do_cmp      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          lfsr_d      = Seed;
          idx_d       = '0;
          num_pat_d   = num_pat_i;
          pass_d      = 1'b1;
          err_cnt_d   = '0;
          first_err_d = '0;
          mask_d      = '0;
          sig_d       = '0;
          state_d     = (num_pat_i == '0) ? StDone : StRun;
        end else if (abort_i) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d  = StIdle;
          stim_d   = '0;
          cmp_en_d = 1'b0;
        end else begin
          do_cmp   = cmp_en_q;
          stim_d   = hold_act ? hold_vec : lfsr_q[4:0];
          cmp_en_d = 1'b1;
          idx_d    = idx_q + CntOne;
          if (!hold_act) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          end
          if (idx_q == num_pat_q - CntOne) state_d = StDrain;
        end
      end
      StDrain: begin
        stim_d   = '0;
        cmp_en_d = 1'b0;
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          do_cmp  = cmp_en_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // stim_q was issued when idx_q was one lower, so it belongs to pattern idx_q-1.
    if (do_cmp) begin
      sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(resp_i);
      if (|diff) begin
        pass_d = 1'b0;
        mask_d = mask_q | diff;
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CntOne;
        if (pass_q) first_err_d = idx_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lfsr_q      <= Seed;
      idx_q       <= '0;
      num_pat_q   <= '0;
      stim_q      <= '0;
      cmp_en_q    <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      mask_q      <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      num_pat_q   <= num_pat_d;
      stim_q      <= stim_d;
      cmp_en_q    <= cmp_en_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      mask_q      <= mask_d;
      sig_q       <= sig_d;
    end
  end

  assign stim_o          = stim_q;
  assign busy_o          = (state_q == StRun) | (state_q == StDrain);
  assign done_o          = (state_q == StDone);
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_idx_o = first_err_q;
  assign err_copy_mask_o = mask_q;
  assign signature_o     = sig_q;

endmodule

// File: tb/tb_c17_stress_bist.sv
// Bench for c17_stress_bist: emulates the c17 copies with injectable faults and checks each run
// against a pattern-list reference model; directed tables plus random fault runs.
module tb_c17_stress_bist;
  localparam int unsigned NCOPIES = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RW      = 2 * NCOPIES;

  logic               clk = 1'b0;
  logic               rst_n, start, abort;
  logic [CNT_W-1:0]   num_pat;
  logic [4:0]         stim;
  logic [RW-1:0]      resp;
  logic               busy, done, pass;
  logic [CNT_W-1:0]   err_cnt, first_err_idx;
  logic [NCOPIES-1:0] mask;
  logic [15:0]        sig;
`ifdef C17_BIST_HOLD_EN
  logic               hold_mode;
  logic [4:0]         hold_vec;
`endif

  c17_stress_bist #(.NCOPIES(NCOPIES), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .abort_i        (abort),
    .num_pat_i      (num_pat),
    .stim_o         (stim),
    .resp_i         (resp),
`ifdef C17_BIST_HOLD_EN
    .hold_mode_i    (hold_mode),
    .hold_vec_i     (hold_vec),
`endif
    .busy_o         (busy),
    .done_o         (done),
    .pass_o         (pass),
    .err_cnt_o      (err_cnt),
    .first_err_idx_o(first_err_idx),
    .err_copy_mask_o(mask),
    .signature_o    (sig)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Fault injection: per-stimulus xor corruption, then forced-1 and forced-0 bit masks.
  logic [RW-1:0] xor_tab [32];
  logic [RW-1:0] or_m, clr_m;
  bit            hold_on = 1'b0;
  logic [4:0]    hold_val = 5'b00000;

  // Reference results of one run.
  logic [4:0]         m_pat [$];
  logic [15:0]        m_sig;
  int                 m_err, m_first;
  logic [NCOPIES-1:0] m_mask;
  bit                 m_pass;

  // c17 outputs in sum-of-products form: {N23, N22}.
  function automatic logic [1:0] gold(input logic [4:0] v);
    logic n1, n2, n3, n6, n7;
    {n7, n6, n3, n2, n1} = v;
    return {~(n3 & n6) & (n2 | n7), (n1 & n3) | (n2 & ~(n3 & n6))};
  endfunction

  function automatic logic [RW-1:0] copies_resp(input logic [4:0] v);
    logic [RW-1:0] r;
    r = {NCOPIES{gold(v)}};
    return ((r ^ xor_tab[v]) | or_m) & ~clr_m;
  endfunction

  always @(negedge clk) resp = copies_resp(stim);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_faults(input logic [RW-1:0] orm, input logic [RW-1:0] clrm);
    for (int v = 0; v < 32; v++) xor_tab[v] = '0;
    or_m  = orm;
    clr_m = clrm;
  endtask

  task automatic model(input int n);
    logic [15:0]   l;
    logic [4:0]    p;
    logic [RW-1:0] r;
    logic [1:0]    g;
    bit            bad;
    l = 16'hACE1;
    m_pat.delete();
    m_sig = '0; m_err = 0; m_first = 0; m_mask = '0; m_pass = 1'b1;
    for (int i = 0; i < n; i++) begin
      p = hold_on ? hold_val : l[4:0];
      if (!hold_on) l = {l[14:0], ^(l & 16'hB400)};
      m_pat.push_back(p);
      r = copies_resp(p);
      g = gold(p);
      m_sig = {m_sig[14:0], ^(m_sig & 16'hB400)} ^ 16'(r);
      bad = 1'b0;
      for (int k = 0; k < int'(NCOPIES); k++) begin
        if (r[2*k +: 2] != g) begin
          m_mask[k] = 1'b1;
          bad = 1'b1;
        end
      end
      if (bad) begin
        if (m_pass) m_first = i;
        m_pass = 1'b0;
        if (m_err < 65535) m_err++;
      end
    end
  endtask

  // One full run compared against the model; pulse_at>0 fires a stray start while busy.
  task automatic run(input string nm, input int n, input int pulse_at);
    int lat, stim_bad;
    model(n);
    @(negedge clk);
    num_pat = CNT_W'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    stim_bad = 0;
    for (int e = 1; e <= n + 20; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (e <= n && stim !== m_pat[e-1]) stim_bad++;
      if (done) begin
        lat = e;
        break;
      end
      if (e == pulse_at) begin
        start   = 1'b1;
        num_pat = CNT_W'(n + 15);
      end
    end
    chk({nm, " latency"}, lat, n + 1);
    chk({nm, " stim seq errors"}, stim_bad, 0);
    chk({nm, " pass"}, 32'(pass), 32'(m_pass));
    chk({nm, " err_cnt"}, 32'(err_cnt), m_err);
    chk({nm, " first_err_idx"}, 32'(first_err_idx), m_first);
    chk({nm, " mask"}, 32'(mask), 32'(m_mask));
    chk({nm, " signature"}, 32'(sig), 32'(m_sig));
    chk({nm, " stim idle"}, 32'(stim), 0);
    chk({nm, " busy idle"}, 32'(busy), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " stim"}, 32'(stim), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " pass"}, 32'(pass), 0);
    chk({nm, " err_cnt"}, 32'(err_cnt), 0);
    chk({nm, " first_err_idx"}, 32'(first_err_idx), 0);
    chk({nm, " mask"}, 32'(mask), 0);
    chk({nm, " signature"}, 32'(sig), 0);
  endtask

  typedef struct {
    int                 n;
    logic [RW-1:0]      orm;
    logic [RW-1:0]      clrm;
    bit                 e_pass;
    int                 e_err;
    int                 e_first;
    logic [NCOPIES-1:0] e_mask;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1,   4'h0, 4'h0, 1'b1, 0, 0, 2'b00};
    tbl[1] = '{0,   4'h0, 4'h0, 1'b1, 0, 0, 2'b00};
    tbl[2] = '{8,   4'h4, 4'h0, 1'b0, 4, 0, 2'b10};  // copy1 N22 stuck at 1
    tbl[3] = '{8,   4'h0, 4'h1, 1'b0, 4, 1, 2'b01};  // copy0 N22 stuck at 0
    tbl[4] = '{256, 4'h0, 4'h0, 1'b1, 0, 0, 2'b00};
    tbl[5] = '{8,   4'h8, 4'h0, 1'b0, 4, 0, 2'b10};  // copy1 N23 stuck at 1

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pat = '0;
`ifdef C17_BIST_HOLD_EN
    hold_mode = 1'b0; hold_vec = '0;
`endif
    set_faults('0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_faults(tbl[i].orm, tbl[i].clrm);
      run($sformatf("tbl%0d", i), tbl[i].n, 0);
      chk($sformatf("tbl%0d hand pass", i), 32'(pass), 32'(tbl[i].e_pass));
      chk($sformatf("tbl%0d hand err_cnt", i), 32'(err_cnt), tbl[i].e_err);
      chk($sformatf("tbl%0d hand first", i), 32'(first_err_idx), tbl[i].e_first);
      chk($sformatf("tbl%0d hand mask", i), 32'(mask), 32'(tbl[i].e_mask));
    end

    for (int r = 0; r < 6; r++) begin
      set_faults('0, '0);
      for (int v = 0; v < 32; v++) xor_tab[v] = ($urandom_range(0, 3) == 0) ? RW'($urandom) : '0;
      run($sformatf("rand%0d", r), int'($urandom_range(1, 40)), 0);
    end

    // Abort after RUN cycle 3: only patterns 0 and 1 have been compared.
    set_faults(4'h4, '0);
    model(2);
    @(negedge clk);
    num_pat = CNT_W'(10);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort busy before", 32'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort stim", 32'(stim), 0);
    chk("abort err_cnt", 32'(err_cnt), m_err);
    chk("abort signature", 32'(sig), 32'(m_sig));
    repeat (3) @(posedge clk);
    #1;
    chk("abort idle busy", 32'(busy), 0);
    chk("abort frozen sig", 32'(sig), 32'(m_sig));
    chk("abort frozen pass", 32'(pass), 32'(m_pass));

    set_faults('0, 4'h2);
    run("busy start", 5, 2);

    // start and abort together in DONE, then in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start+abort done", 32'(done), 0);
    chk("start+abort busy", 32'(busy), 0);
    chk("start+abort pass held", 32'(pass), 32'(m_pass));
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start+abort idle busy", 32'(busy), 0);

    // Reset in the middle of a faulty run.
    set_faults('0, 4'h1);
    @(negedge clk);
    num_pat = CNT_W'(20);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_all_zero("midrun reset");

`ifdef C17_BIST_HOLD_EN
    set_faults('0, '0);
    hold_on = 1'b1; hold_val = 5'b11111;
    hold_mode = 1'b1; hold_vec = 5'b11111;
    run("hold", 4, 0);
    chk("hold pass", 32'(pass), 1);
    hold_on = 1'b0; hold_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
